// File: rtl/pc_ctrl_pkg.sv
// Shared types for the PC redirect controller: FSM states, redirect sources, pending entry.
// Source encoding doubles as priority rank (TRAP > EX > ID > NONE).
package pc_ctrl_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } pc_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ID   = 2'd1,
    EX   = 2'd2,
    TRAP = 2'd3
  } redir_src_e;

  typedef struct packed {
    redir_src_e              src;
    logic [ADDR_W-1:0]       target;
  } pend_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

  // A fresh redirect replaces a held one only if it is a trap, or EX displacing an ID jump.
  function automatic logic preempts(input redir_src_e new_src, input redir_src_e held_src);
    return (new_src == TRAP) || ((new_src == EX) && (held_src == ID));
  endfunction

  function automatic logic kills_id_ex(input redir_src_e src);
    return (src == EX) || (src == TRAP);
  endfunction

endpackage

// File: rtl/pc_redir_arb.sv
// Combinational fixed-priority redirect picker (trap > EX > ID), word-aligned target, zero latency.
// Trap inputs only take part when PC_CTRL_TRAP_EN is defined; no backpressure (pure select).
import pc_ctrl_pkg::*;

module pc_redir_arb (
  input  logic              trap_valid,
  input  logic [ADDR_W-1:0] trap_target,
  input  logic              ex_redir_valid,
  input  logic [ADDR_W-1:0] ex_redir_target,
  input  logic              id_redir_valid,
  input  logic [ADDR_W-1:0] id_redir_target,
  output redir_src_e        sel_src,
  output logic [ADDR_W-1:0] sel_target
);

  logic trap_hit;

`ifdef PC_CTRL_TRAP_EN
  assign trap_hit = trap_valid;
`else
  logic unused_trap_valid;
  assign unused_trap_valid = trap_valid;
  assign trap_hit          = 1'b0;
`endif

  always_comb begin
    sel_src    = NONE;
    sel_target = '0;
    if (trap_hit) begin
      sel_src    = TRAP;
      sel_target = word_align(trap_target);
    end else if (ex_redir_valid) begin
      sel_src    = EX;
      sel_target = word_align(ex_redir_target);
    end else if (id_redir_valid) begin
      sel_src    = ID;
      sel_target = word_align(id_redir_target);
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// PC redirect/stall controller: same-cycle redirect when imem_ready, else hold in PEND until accepted.
// Zero added latency on redirects; keep_pc backpressures the PC while fetch is not accepted. Option: PC_CTRL_TRAP_EN.
import pc_ctrl_pkg::*;

module pc_ctrl (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_ready,
  input  logic              load_use_hazard,
  input  logic              ex_redir_valid,
  input  logic [ADDR_W-1:0] ex_redir_target,
  input  logic              id_redir_valid,
  input  logic [ADDR_W-1:0] id_redir_target,
  input  logic              trap_valid,
  input  logic [ADDR_W-1:0] trap_target,
  output logic              keep_pc,
  output logic              branch_op,
  output logic [ADDR_W-1:0] branch_target,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              redir_pending
);

  pc_state_e         state_q, state_d;
  pend_t             pend_q, pend_d;
  redir_src_e        arb_src;
  logic [ADDR_W-1:0] arb_target;
  redir_src_e        issue_src;
  logic [ADDR_W-1:0] issue_target;
  logic              run_take;

  pc_redir_arb u_arb (
    .trap_valid      (trap_valid),
    .trap_target     (trap_target),
    .ex_redir_valid  (ex_redir_valid),
    .ex_redir_target (ex_redir_target),
    .id_redir_valid  (id_redir_valid),
    .id_redir_target (id_redir_target),
    .sel_src         (arb_src),
    .sel_target      (arb_target)
  );

  // A load-use stall outranks an ID jump; ID re-raises it once the bubble clears.
  assign run_take = (arb_src != NONE) && !(load_use_hazard && (arb_src == ID));

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    issue_src     = NONE;
    issue_target  = '0;
    keep_pc       = 1'b0;
    branch_op     = 1'b0;
    branch_target = '0;
    stall_if_id   = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;

    if (!rst) begin
      case (state_q)
        RUN: begin
          if (run_take) begin
            if (imem_ready) begin
              issue_src    = arb_src;
              issue_target = arb_target;
            end else begin
              keep_pc       = 1'b1;
              pend_d.src    = arb_src;
              pend_d.target = arb_target;
              state_d       = PEND;
            end
          end else if (load_use_hazard) begin
            keep_pc     = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else begin
            keep_pc = ~imem_ready;
          end
        end
        PEND: begin
          if (imem_ready) begin
            if (preempts(arb_src, pend_q.src)) begin
              issue_src    = arb_src;
              issue_target = arb_target;
            end else begin
              issue_src    = pend_q.src;
              issue_target = pend_q.target;
            end
            pend_d  = '0;
            state_d = RUN;
          end else begin
            keep_pc = 1'b1;
            if (preempts(arb_src, pend_q.src)) begin
              pend_d.src    = arb_src;
              pend_d.target = arb_target;
            end
          end
        end
        default: state_d = RUN;
      endcase

      if (issue_src != NONE) begin
        branch_op     = 1'b1;
        branch_target = issue_target;
        flush_if_id   = 1'b1;
        flush_id_ex   = kills_id_ex(issue_src);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  assign redir_pending = (state_q == PEND) && !rst;

  a_keep_vs_branch: assert property (@(posedge clk) !(keep_pc && branch_op));

endmodule
